// File: rtl/gpr_wb_sched_pkg.sv
// gpr_wb_sched_pkg: shared constants for the GPR writeback scheduler.
`default_nettype none

package gpr_wb_sched_pkg;

  localparam int NREQ = 3;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;
  localparam int REQ_CSR = 2;

  localparam logic [4:0] X0_IDX = 5'd0;

endpackage

`default_nettype wire

// File: rtl/gpr_wb_sched_rr_arb.sv
// rr_arb: one-hot round-robin arbiter; the pointer moves past the winner only when advance is high.
`default_nettype none

module rr_arb #(
  parameter int N = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [N-1:0] req,
  input  logic         advance,
  output logic [N-1:0] grant
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] gidx;
  logic [PW-1:0] idx;
  int            sum;

  // Walk offsets from farthest to nearest so the requester closest to the pointer wins.
  always_comb begin
    grant = '0;
    gidx  = ptr_q;
    idx   = '0;
    sum   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      sum = int'(ptr_q) + k;
      if (sum >= N) begin
        sum = sum - N;
      end
      idx = PW'(sum);
      if (req[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gidx       = idx;
      end
    end
  end

  always_comb begin
    ptr_d = ptr_q;
    if (advance) begin
      ptr_d = (gidx == PW'(N - 1)) ? '0 : gidx + PW'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/gpr_wb_sched.sv
// gpr_wb_sched: round-robin GPR writeback arbiter with a registered write port and
// an optional busy scoreboard enabled by the macro GPR_WB_SCB_EN.
`default_nettype none

module gpr_wb_sched #(
  parameter int NREQ = gpr_wb_sched_pkg::NREQ,
  parameter int XLEN = 32
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [NREQ-1:0]      req_valid,
  output logic [NREQ-1:0]      req_ready,
  input  logic [NREQ*5-1:0]    req_rd,
  input  logic [NREQ*XLEN-1:0] req_data,
  input  logic                 gpr_ready,
  output logic                 wr_valid,
  output logic [4:0]           wr_idx,
  output logic [XLEN-1:0]      wr_data,
  input  logic                 issue_valid,
  input  logic [4:0]           issue_rd,
  output logic                 issue_ready,
  input  logic [4:0]           rs1_idx,
  input  logic [4:0]           rs2_idx,
  output logic                 rs1_busy,
  output logic                 rs2_busy
);

  import gpr_wb_sched_pkg::*;

  logic [NREQ-1:0] grant;
  logic            hs;
  logic [4:0]      sel_rd;
  logic [XLEN-1:0] sel_data;

  logic            wr_valid_q, wr_valid_d;
  logic [4:0]      wr_idx_q, wr_idx_d;
  logic [XLEN-1:0] wr_data_q, wr_data_d;

  rr_arb #(.N(NREQ)) u_rr_arb (
    .clk     (clk),
    .rstn    (rstn),
    .req     (req_valid),
    .advance (hs),
    .grant   (grant)
  );

  // Gating with rstn keeps accepts low throughout reset, not just after the first edge.
  assign req_ready = grant & {NREQ{gpr_ready & rstn}};
  assign hs        = |(req_valid & req_ready);

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_rd   = req_rd[i*5 +: 5];
        sel_data = req_data[i*XLEN +: XLEN];
      end
    end
  end

  // Writes to x0 are consumed and loaded but never presented to the register file.
  always_comb begin
    wr_valid_d = hs && (sel_rd != X0_IDX);
    wr_idx_d   = hs ? sel_rd : wr_idx_q;
    wr_data_d  = hs ? sel_data : wr_data_q;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_valid_q <= 1'b0;
      wr_idx_q   <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_idx_q   <= wr_idx_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_valid = wr_valid_q;
  assign wr_idx   = wr_idx_q;
  assign wr_data  = wr_data_q;

`ifdef GPR_WB_SCB_EN
  logic [31:0] busy_q, busy_d;

  assign issue_ready = (issue_rd == X0_IDX) || !busy_q[issue_rd];

  // Clear first so that a same-edge set on the same index takes precedence.
  always_comb begin
    busy_d = busy_q;
    if (wr_valid_q) begin
      busy_d[wr_idx_q] = 1'b0;
    end
    if (issue_valid && issue_ready && (issue_rd != X0_IDX)) begin
      busy_d[issue_rd] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  assign rs1_busy = busy_q[rs1_idx];
  assign rs2_busy = busy_q[rs2_idx];
`else
  logic unused_scb;
  assign unused_scb  = ^{issue_valid, issue_rd, rs1_idx, rs2_idx};
  assign issue_ready = 1'b1;
  assign rs1_busy    = 1'b0;
  assign rs2_busy    = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_gpr_wb_sched.sv
// tb_gpr_wb_sched: directed vector table plus hand-written scoreboard and reset sequences.
`default_nettype none

module tb_gpr_wb_sched;

  localparam int NREQ = 3;
  localparam int XLEN = 32;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ-1:0]      req_ready;
  logic [NREQ*5-1:0]    req_rd;
  logic [NREQ*XLEN-1:0] req_data;
  logic                 gpr_ready;
  logic                 wr_valid;
  logic [4:0]           wr_idx;
  logic [XLEN-1:0]      wr_data;
  logic                 issue_valid;
  logic [4:0]           issue_rd;
  logic                 issue_ready;
  logic [4:0]           rs1_idx;
  logic [4:0]           rs2_idx;
  logic                 rs1_busy;
  logic                 rs2_busy;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  gpr_wb_sched #(.NREQ(NREQ), .XLEN(XLEN)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_rd      (req_rd),
    .req_data    (req_data),
    .gpr_ready   (gpr_ready),
    .wr_valid    (wr_valid),
    .wr_idx      (wr_idx),
    .wr_data     (wr_data),
    .issue_valid (issue_valid),
    .issue_rd    (issue_rd),
    .issue_ready (issue_ready),
    .rs1_idx     (rs1_idx),
    .rs2_idx     (rs2_idx),
    .rs1_busy    (rs1_busy),
    .rs2_busy    (rs2_busy)
  );

  typedef struct {
    logic [2:0]  valid;
    logic [14:0] rd;     // {CSR, MEM, ALU}
    logic [95:0] data;   // {CSR, MEM, ALU}
    logic        gr;
    logic [2:0]  rdy;
    logic        wv;
    logic [4:0]  widx;
    logic [31:0] wdata;
  } vec_t;

  vec_t tv [14];

  function automatic vec_t mk(input logic [2:0] valid, input logic [14:0] rd,
                              input logic [95:0] data, input logic gr,
                              input logic [2:0] rdy, input logic wv,
                              input logic [4:0] widx, input logic [31:0] wdata);
    vec_t v;
    v.valid = valid; v.rd = rd; v.data = data; v.gr = gr;
    v.rdy = rdy; v.wv = wv; v.widx = widx; v.wdata = wdata;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [14:0] rd3;
    logic [95:0] dt3;
    rd3 = {5'd3, 5'd2, 5'd1};
    dt3 = {32'h33, 32'h22, 32'h11};

    tv[0]  = mk(3'b111, rd3, dt3, 1'b1, 3'b001, 1'b1, 5'd1, 32'h11);
    tv[1]  = mk(3'b111, rd3, dt3, 1'b1, 3'b010, 1'b1, 5'd2, 32'h22);
    tv[2]  = mk(3'b111, rd3, dt3, 1'b1, 3'b100, 1'b1, 5'd3, 32'h33);
    tv[3]  = mk(3'b111, rd3, dt3, 1'b1, 3'b001, 1'b1, 5'd1, 32'h11);
    tv[4]  = mk(3'b010, {5'd0, 5'd5, 5'd0}, {32'h0, 32'hDEADBEEF, 32'h0},
                1'b1, 3'b010, 1'b1, 5'd5, 32'hDEADBEEF);
    tv[5]  = mk(3'b000, rd3, dt3, 1'b1, 3'b000, 1'b0, 5'd5, 32'hDEADBEEF);
    tv[6]  = mk(3'b001, {5'd0, 5'd0, 5'd0}, {32'h0, 32'h0, 32'h1234},
                1'b1, 3'b001, 1'b0, 5'd0, 32'h1234);
    tv[7]  = mk(3'b011, {5'd0, 5'd6, 5'd4}, {32'h0, 32'h66, 32'h44},
                1'b1, 3'b010, 1'b1, 5'd6, 32'h66);
    tv[8]  = mk(3'b111, rd3, dt3, 1'b0, 3'b000, 1'b0, 5'd6, 32'h66);
    tv[9]  = mk(3'b111, rd3, dt3, 1'b0, 3'b000, 1'b0, 5'd6, 32'h66);
    tv[10] = mk(3'b111, rd3, dt3, 1'b0, 3'b000, 1'b0, 5'd6, 32'h66);
    tv[11] = mk(3'b111, rd3, dt3, 1'b1, 3'b100, 1'b1, 5'd3, 32'h33);
    tv[12] = mk(3'b101, rd3, dt3, 1'b1, 3'b001, 1'b1, 5'd1, 32'h11);
    tv[13] = mk(3'b101, rd3, dt3, 1'b1, 3'b100, 1'b1, 5'd3, 32'h33);

    rstn        = 1'b0;
    req_valid   = 3'b111;
    req_rd      = rd3;
    req_data    = dt3;
    gpr_ready   = 1'b1;
    issue_valid = 1'b0;
    issue_rd    = 5'd0;
    rs1_idx     = 5'd0;
    rs2_idx     = 5'd0;

    #12;
    chk("rst_req_ready", 32'(req_ready), 32'h0);
    chk("rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("rst_wr_idx", 32'(wr_idx), 32'h0);
    chk("rst_wr_data", wr_data, 32'h0);
    chk("rst_issue_ready", 32'(issue_ready), 32'h1);
    chk("rst_rs1_busy", 32'(rs1_busy), 32'h0);
    req_valid = 3'b000;
    rstn      = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 14; i++) begin
      req_valid = tv[i].valid;
      req_rd    = tv[i].rd;
      req_data  = tv[i].data;
      gpr_ready = tv[i].gr;
      #1;
      chk($sformatf("v%0d_req_ready", i), 32'(req_ready), 32'(tv[i].rdy));
      @(posedge clk); #1;
      chk($sformatf("v%0d_wr_valid", i), 32'(wr_valid), 32'(tv[i].wv));
      chk($sformatf("v%0d_wr_idx", i), 32'(wr_idx), 32'(tv[i].widx));
      chk($sformatf("v%0d_wr_data", i), wr_data, tv[i].wdata);
    end
    req_valid = 3'b000;
    gpr_ready = 1'b1;

`ifdef GPR_WB_SCB_EN
    issue_rd    = 5'd7;
    issue_valid = 1'b1;
    rs1_idx     = 5'd7;
    #1;
    chk("scb_issue7_ready", 32'(issue_ready), 32'h1);
    chk("scb_rs1_pre", 32'(rs1_busy), 32'h0);
    @(posedge clk); #1;
    chk("scb_rs1_busy7", 32'(rs1_busy), 32'h1);
    chk("scb_rs2_x0", 32'(rs2_busy), 32'h0);
    chk("scb_waw_stall", 32'(issue_ready), 32'h0);
    issue_valid = 1'b0;
    req_valid   = 3'b100;
    req_rd      = {5'd7, 5'd0, 5'd0};
    req_data    = {32'h77, 32'h0, 32'h0};
    #1;
    chk("scb_csr_ready", 32'(req_ready), 32'h4);
    @(posedge clk); #1;
    req_valid = 3'b000;
    chk("scb_csr_wr_valid", 32'(wr_valid), 32'h1);
    chk("scb_csr_wr_idx", 32'(wr_idx), 32'd7);
    chk("scb_busy_until_write", 32'(rs1_busy), 32'h1);
    @(posedge clk); #1;
    chk("scb_rs1_cleared", 32'(rs1_busy), 32'h0);
    chk("scb_issue7_free", 32'(issue_ready), 32'h1);
`else
    issue_rd    = 5'd7;
    issue_valid = 1'b1;
    rs1_idx     = 5'd7;
    #1;
    chk("noscb_issue_ready", 32'(issue_ready), 32'h1);
    @(posedge clk); #1;
    chk("noscb_issue_ready2", 32'(issue_ready), 32'h1);
    chk("noscb_rs1_busy", 32'(rs1_busy), 32'h0);
    issue_valid = 1'b0;
`endif

    req_valid   = 3'b010;
    req_rd      = {5'd0, 5'd9, 5'd0};
    req_data    = {32'h0, 32'h99, 32'h0};
    issue_rd    = 5'd3;
    issue_valid = 1'b1;
    rs1_idx     = 5'd3;
    @(posedge clk); #1;
    issue_valid = 1'b0;
    req_valid   = 3'b111;
    req_rd      = rd3;
    req_data    = dt3;
    gpr_ready   = 1'b0;
    chk("mid_wr_valid", 32'(wr_valid), 32'h1);
`ifdef GPR_WB_SCB_EN
    chk("mid_rs1_busy3", 32'(rs1_busy), 32'h1);
`endif
    rstn = 1'b0;
    #1;
    chk("mid_rst_wr_valid", 32'(wr_valid), 32'h0);
    chk("mid_rst_wr_idx", 32'(wr_idx), 32'h0);
    chk("mid_rst_wr_data", wr_data, 32'h0);
    chk("mid_rst_rs1_busy", 32'(rs1_busy), 32'h0);
    chk("mid_rst_req_ready", 32'(req_ready), 32'h0);
    #1;
    rstn      = 1'b1;
    gpr_ready = 1'b1;
    #1;
    chk("post_rst_ptr_alu", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    chk("post_rst_wr_idx", 32'(wr_idx), 32'd1);
    chk("post_rst_wr_data", wr_data, 32'h11);

    req_valid = 3'b000;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
